// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle shift-add multiplier / restoring divider with HI/LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        divzero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_n, prod;
  logic [31:0] m, ma, mb, quo, rem;
  logic [32:0] sum, trial, diff;
  logic        is_div, neg_p, neg_r, dz, a_neg, b_neg, ge;
  always_comb begin
    a_neg = ~op[0] & a[31];
    b_neg = ~op[0] & b[31];
    ma = a_neg ? -a : a;
    mb = b_neg ? -b : b;
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    trial = acc[63:31];
    ge = trial >= {1'b0, m};
    diff = trial - {1'b0, m};
    acc_n = is_div ? {ge ? diff[31:0] : trial[31:0], acc[30:0], ge} : {sum, acc[31:1]};
    prod = neg_p ? -acc_n : acc_n;
    quo = neg_p ? -acc_n[31:0] : acc_n[31:0];
    rem = neg_r ? -acc_n[63:32] : acc_n[63:32];
    state_next = state;
    state_next = state == IDLE ? (start ? ((op[1] && b == 32'd0) ? DONE : RUN) : IDLE)
               : state == RUN  ? (cnt == 6'd31 ? DONE : RUN)
               : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 6'd0;
      hi <= 32'd0;
      lo <= 32'd0;
      dz <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        is_div <= op[1];
        m <= op[1] ? mb : ma;
        acc <= {32'd0, op[1] ? ma : mb};
        neg_p <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt <= 6'd0;
        dz <= op[1] && b == 32'd0;
      end else if (state == IDLE) begin
        if (mthi) hi <= a;
        if (mtlo) lo <= a;
      end
      if (state == RUN) begin
        acc <= acc_n;
        cnt <= cnt + 6'd1;
        if (cnt == 6'd31) begin
          hi <= is_div ? rem : prod[63:32];
          lo <= is_div ? quo : prod[31:0];
        end
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign divzero = state == DONE && dz;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 SHALL have port: a  input  32  operand A (multiplicand or dividend; also mthi/mtlo data).
REQ-006 SHALL have port: b  input  32  operand B (multiplier or divisor).
REQ-007 SHALL have port: mthi  input  1  write a into HI at next edge.
REQ-008 SHALL have port: mtlo  input  1  write a into LO at next edge.
REQ-009 SHALL have port: hi  output  32  HI register.
REQ-010 SHALL have port: lo  output  32  LO register.
REQ-011 SHALL have port: busy  output  1  high in every RUN cycle.
REQ-012 SHALL have port: done  output  1  one-cycle pulse in DONE state.
REQ-013 SHALL have port: divzero  output  1  high with done when a DIV/DIVU had b == 0.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-015 IDLE with start=1 SHALL latch a, b, op and a 6-bit counter = 0; transition to RUN, except a division with b == 0, which transitions directly to DONE.
REQ-016 RUN SHALL perform one iteration per cycle for exactly 32 cycles (counter 0..31), then transition to DONE.
REQ-017 Multiply SHALL use shift-add on operand magnitudes; signed MULT SHALL negate the 64-bit product when the operand signs differ.
REQ-018 Divide SHALL use restoring division on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (truncating division).
REQ-019 MULT/MULTU SHALL load product[63:32] into hi and product[31:0] into lo on the RUN->DONE edge.
REQ-020 DIV/DIVU SHALL load remainder into hi and quotient into lo on the RUN->DONE edge.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0 (no trap).
REQ-022 Division by zero SHALL leave hi and lo unchanged and assert divzero=1 together with done.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 Latency: for start sampled at edge N, done SHALL be high in the cycle after edge N+33 (edge N+1 for divide-by-zero).
REQ-025 start asserted in RUN or DONE SHALL be ignored; operands SHALL NOT be re-sampled.
REQ-026 Changes to a, b, op during RUN SHALL NOT affect the result.
REQ-027 mthi/mtlo SHALL take effect only in IDLE with start=0; they SHALL be ignored in RUN and DONE, and when start=1.
REQ-028 mthi and mtlo asserted together SHALL write a into both HI and LO.
REQ-029 hi and lo SHALL remain stable throughout RUN and DONE except for the single update of REQ-019/020.

Reset
REQ-030 reset=1 SHALL force IDLE, counter=0, hi=0, lo=0, busy=0, done=0, divzero=0 at the next edge, with priority over start, mthi, mtlo.
REQ-031 reset during RUN SHALL abort the operation; no done pulse SHALL follow, and hi/lo SHALL read 0.

Verification
REQ-032 MULT a=50, b=100 -> done after 33 cycles; hi=0x00000000, lo=0x00001388.
REQ-033 MULT a=-5, b=-10 -> hi=0, lo=50; then MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-035 mthi with a=0x12345678 in IDLE, then DIV a=5, b=0 -> done and divzero high at edge N+1; hi=0x12345678 unchanged.
REQ-036 MULT a=0 and b=0 started, reset asserted at RUN cycle 10 -> next cycle busy=0, hi=lo=0; no done pulse within 40 cycles.
REQ-037 start re-asserted and mtlo asserted during RUN with new operands -> both ignored; the original result is written at DONE.
